bfetch_packet_queue: RTL and testbench
======================================

Name: bfetch_packet_queue

Overview:
- Clocked consumer of the branch-predict stage's per-packet output (next PC, cut position, aligned instruction table).
- Bridges the predictor's 2-phase drive/free handshake into the clocked decode domain.
- Buffers packets in a small FIFO and presents them to decode with valid/ready.
- Supports a decode-initiated flush on redirect.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- INSTR_W, 640, width of the aligned instruction table bus (64 bits x 10 slots).
- SYNC_STAGES, 2, synchronizer flops on the incoming drive toggle; minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- i_drive  in  1  2-phase request from the predict stage; each transition announces one packet
- i_nextPc_32  in  32  bundled data: next fetch PC of the packet
- i_cutPosition_8  in  8  bundled data: per-slot valid mask after the branch cut
- i_instr  in  INSTR_W  bundled data: aligned instruction table
- o_free  out  1  2-phase acknowledge to the predict stage; each transition releases one packet
- o_valid  out  1  head entry valid to decode
- i_ready  in  1  decode accepts the head entry
- o_pc_32  out  32  head next-PC
- o_cutPosition_8  out  8  head cut mask
- o_instr  out  INSTR_W  head instruction table
- o_count_4  out  4  head popcount of o_cutPosition_8, range 0..8
- i_flush  in  1  synchronous flush from decode/redirect
- o_level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=0, asynchronous): sync chain and the previous-sample flop cleared; o_free=0; read/write pointers=0; o_level=0; o_valid=0; data outputs 0. i_drive must be 0 during reset.
- Request detect: i_drive passes through SYNC_STAGES flops. A request is captured when the last sync flop differs from a stored previous-sample flop; previous-sample updates every cycle. Capture occurs SYNC_STAGES+1 edges after the i_drive toggle.
- Capture: bundled data sampled on the capture edge. Bundled data is stable from the drive toggle until the free toggle, so no data synchronizer is used.
- Accept, not full: entry written at the write pointer (increments, wraps mod DEPTH); o_free toggles on the same edge.
- Accept, full: request held in a pending flag; no write, no free. On the first cycle with space (pop or flush), the pending packet is written, then o_free toggles. At most one request is outstanding, because the predictor waits for free.
- Pop: o_valid=1 when level>0. On o_valid&i_ready the read pointer increments (wraps mod DEPTH).
- Simultaneous pop and capture: when full, the captured or pending write succeeds in the same cycle; when empty, o_valid is low so no pop occurs. Level is unchanged by a same-cycle push and pop.
- Output timing: FIFO is registered-write / combinational-read. Head outputs reflect the entry at the read pointer; latency from capture to o_valid is 1 cycle.
- o_count_4 is the combinational popcount of the head cut mask; 0 when empty.
- Flush (i_flush=1, highest priority): pointers and level cleared; any pending request is discarded but still acknowledged (o_free toggles) to avoid deadlock; a capture in the same cycle is also dropped and acknowledged; pops are ignored. o_valid=0 the next cycle.
- Reset mid-operation: all state cleared regardless of pending request; o_free returns to 0. The predictor side is reset together with this block.

Test Plan:
- Reset then single packet (PC=0x0000_1040, cut=0x1F): toggle i_drive 0->1 -> capture after 3 edges, o_free 0->1 on the same edge, o_valid next cycle, o_pc_32=0x1040, o_count_4=5.
- Fill with i_ready=0, 5 packets at DEPTH=4: 4 captured with 4 free toggles, o_level=4; 5th held with no free toggle. Assert i_ready for 1 cycle -> pop, pending written, 5th free toggle, o_level stays 4.
- Streaming with i_ready=1: 8 back-to-back packets with PCs 0x100..0x800 -> exact order out, no loss, o_level never exceeds 2.
- Wrap-around: push/pop 10 packets at DEPTH=4 -> pointers wrap, data order correct, cut 0xFF gives o_count_4=8, cut 0x00 gives 0.
- Flush while full with one pending: i_flush=1 for 1 cycle -> o_level=0, o_valid=0 next cycle, pending acknowledged with one free toggle, no stale packet emitted later.
- Async reset asserted mid-stream with o_free=1 -> o_free=0, o_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bfetch_packet_queue.sv
// Branch-predict packet queue: 2-phase drive/free ingress,
// small FIFO, valid/ready egress to decode with flush.
module bfetch_packet_queue #(
  parameter int DEPTH       = 4,
  parameter int INSTR_W     = 640,
  parameter int SYNC_STAGES = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_drive,
  input  logic [31:0]        i_nextPc_32,
  input  logic [7:0]         i_cutPosition_8,
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_free,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [31:0]        o_pc_32,
  output logic [7:0]         o_cutPosition_8,
  output logic [INSTR_W-1:0] o_instr,
  output logic [3:0]         o_count_4,
  input  logic               i_flush,
  output logic [LW-1:0]      o_level
);

  typedef struct packed {
    logic [31:0]        pc;
    logic [7:0]         cut;
    logic [INSTR_W-1:0] instr;
  } pkt_t;

  pkt_t                   mem [DEPTH];
  pkt_t                   head;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   pend_q;
  logic [PW-1:0]          wptr_q;
  logic [PW-1:0]          rptr_q;
  logic [LW-1:0]          level_q;

  logic req;
  logic want;
  logic full;
  logic pop;
  logic wr;
  logic ack;

  assign req  = sync_q[SYNC_STAGES-1] ^ prev_q;
  assign want = req | pend_q;
  assign full = (level_q == LW'(DEPTH));
  assign pop  = o_valid & i_ready & ~i_flush;
  assign wr   = ~i_flush & want & (~full | pop);
  // A flushed request is still acknowledged so the predictor never stalls.
  assign ack  = wr | (i_flush & want);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pend_q  <= 1'b0;
      o_free  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_drive};
      prev_q <= sync_q[SYNC_STAGES-1];
      pend_q <= ~i_flush & want & ~wr;
      if (ack) o_free <= ~o_free;
      if (i_flush) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        level_q <= '0;
      end else begin
        if (wr)  wptr_q <= wptr_q + PW'(1);
        if (pop) rptr_q <= rptr_q + PW'(1);
        level_q <= level_q + LW'(wr) - LW'(pop);
      end
    end
  end

  // Bundled data is held stable until free toggles, so sample directly.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr_q] <= '{pc:    i_nextPc_32,
                       cut:   i_cutPosition_8,
                       instr: i_instr};
    end
  end

  assign o_valid = (level_q != '0);
  assign head    = o_valid ? mem[rptr_q] : '0;

  assign o_pc_32         = head.pc;
  assign o_cutPosition_8 = head.cut;
  assign o_instr         = head.instr;
  assign o_level         = level_q;

  always_comb begin
    o_count_4 = '0;
    for (int i = 0; i < 8; i++) begin
      o_count_4 = o_count_4 + 4'(head.cut[i]);
    end
  end

endmodule

// File: tb/tb_bfetch_packet_queue.sv
// Self-checking bench for bfetch_packet_queue: predictor model
// on the 2-phase side, scoreboard checked at every decode pop.
module tb_bfetch_packet_queue;

  localparam int DEPTH   = 4;
  localparam int INSTR_W = 640;
  localparam int LW      = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  cut;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               i_drive;
  logic [31:0]        i_nextPc_32;
  logic [7:0]         i_cutPosition_8;
  logic [INSTR_W-1:0] i_instr;
  logic               o_free;
  logic               o_valid;
  logic               i_ready;
  logic [31:0]        o_pc_32;
  logic [7:0]         o_cutPosition_8;
  logic [INSTR_W-1:0] o_instr;
  logic [3:0]         o_count_4;
  logic               i_flush;
  logic [LW-1:0]      o_level;

  int   checks;
  int   errors;
  int   pops;
  int   max_lvl;
  exp_t sb[$];

  bfetch_packet_queue #(
    .DEPTH(DEPTH), .INSTR_W(INSTR_W), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .i_drive(i_drive),
    .i_nextPc_32(i_nextPc_32),
    .i_cutPosition_8(i_cutPosition_8),
    .i_instr(i_instr),
    .o_free(o_free),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_pc_32(o_pc_32),
    .o_cutPosition_8(o_cutPosition_8),
    .o_instr(o_instr),
    .o_count_4(o_count_4),
    .i_flush(i_flush),
    .o_level(o_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] instr_of(logic [31:0] pc);
    return {20{pc ^ 32'hA5A5_0000}};
  endfunction

  // Every accepted head must match the oldest expected packet.
  always @(negedge clk) begin
    if (rst && !i_flush && o_valid && i_ready) begin
      exp_t e;
      pops++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected pc got %h want none", o_pc_32);
      end else begin
        e = sb.pop_front();
        if (o_pc_32 !== e.pc || o_cutPosition_8 !== e.cut ||
            o_instr !== instr_of(e.pc) ||
            o_count_4 !== 4'($countones(e.cut))) begin
          errors++;
          $display("FAIL pop_data pc got %h want %h cut got %h want %h cnt got %0d",
                   o_pc_32, e.pc, o_cutPosition_8, e.cut, o_count_4);
        end
      end
    end
    if (o_level > max_lvl) max_lvl = o_level;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_free(input string name);
    int n = 0;
    while (o_free !== i_drive && n < 20) begin
      tick();
      n++;
    end
    if (o_free !== i_drive) begin
      checks++;
      errors++;
      $display("FAIL %s free_timeout got %b want %b", name, o_free, i_drive);
    end
  endtask

  task automatic toggle(input logic [31:0] pc, input logic [7:0] cut);
    exp_t e;
    i_nextPc_32     = pc;
    i_cutPosition_8 = cut;
    i_instr         = instr_of(pc);
    i_drive         = ~i_drive;
    e.pc  = pc;
    e.cut = cut;
    sb.push_back(e);
  endtask

  task automatic send(input logic [31:0] pc, input logic [7:0] cut);
    toggle(pc, cut);
    wait_free("send");
  endtask

  task automatic drain();
    int n = 0;
    i_ready = 1'b1;
    while (o_level != 0 && n < 40) begin
      tick();
      n++;
    end
    i_ready = 1'b0;
    checks++;
    if (o_level !== 0 || sb.size() != 0) begin
      errors++;
      $display("FAIL drain level got %0d want 0 sb %0d", o_level, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_drive = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
    i_nextPc_32 = '0; i_cutPosition_8 = '0; i_instr = '0;
    repeat (3) tick();
    checks++;
    if (o_free !== 1'b0 || o_valid !== 1'b0 || o_level !== 0 ||
        o_pc_32 !== 0 || o_count_4 !== 0 || o_instr !== '0) begin
      errors++;
      $display("FAIL reset free %b valid %b level %0d pc %h want 0",
               o_free, o_valid, o_level, o_pc_32);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    toggle(32'h0000_1040, 8'h1F);
    tick(); tick();
    checks++;
    if (o_free !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early free %b valid %b want 0 0", o_free, o_valid);
    end
    tick();
    checks++;
    if (o_free !== 1'b1 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_capture free %b valid %b want 1 1", o_free, o_valid);
    end
    checks++;
    if (o_pc_32 !== 32'h1040 || o_count_4 !== 4'd5 || o_level !== 1) begin
      errors++;
      $display("FAIL single_head pc %h cnt %0d lvl %0d want 1040 5 1",
               o_pc_32, o_count_4, o_level);
    end
    drain();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) send(32'h2000 + 32'(i * 4), 8'h03);
    checks++;
    if (o_level !== 4) begin
      errors++;
      $display("FAIL fill_level got %0d want 4", o_level);
    end
    toggle(32'h2010, 8'h07);
    repeat (6) tick();
    checks++;
    if (o_free === i_drive || o_level !== 4) begin
      errors++;
      $display("FAIL fill_pending free %b drive %b lvl %0d want held 4",
               o_free, i_drive, o_level);
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    checks++;
    if (o_free !== i_drive || o_level !== 4) begin
      errors++;
      $display("FAIL fill_release free %b drive %b lvl %0d want ack 4",
               o_free, i_drive, o_level);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int p0 = pops;
    max_lvl = 0;
    i_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(32'h100 * 32'(i), 8'h0F);
    repeat (3) tick();
    drain();
    checks++;
    if (pops - p0 != 8 || max_lvl > 2) begin
      errors++;
      $display("FAIL stream pops got %0d want 8 maxlvl %0d want <=2",
               pops - p0, max_lvl);
    end
  endtask

  task automatic test_wrap();
    toggle(32'h3000, 8'hFF);
    wait_free("wrap_ff");
    checks++;
    if (o_count_4 !== 4'd8) begin
      errors++;
      $display("FAIL wrap_cnt_ff got %0d want 8", o_count_4);
    end
    drain();
    toggle(32'h3004, 8'h00);
    wait_free("wrap_00");
    checks++;
    if (o_count_4 !== 4'd0 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_cnt_00 got %0d valid %b want 0 1", o_count_4, o_valid);
    end
    drain();
    i_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(32'h4000 + 32'(i), 8'(8'h81 << (i % 4)));
    repeat (3) tick();
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) send(32'h5000 + 32'(i), 8'h01);
    toggle(32'h5004, 8'h01);
    repeat (6) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    sb.delete();
    checks++;
    if (o_level !== 0 || o_valid !== 1'b0 || o_free !== i_drive) begin
      errors++;
      $display("FAIL flush lvl %0d valid %b free %b want 0 0 %b",
               o_level, o_valid, o_free, i_drive);
    end
    repeat (10) tick();
    checks++;
    if (o_valid !== 1'b0 || o_free !== i_drive) begin
      errors++;
      $display("FAIL flush_stale valid %b free %b want 0 %b",
               o_valid, o_free, i_drive);
    end
    send(32'h6000, 8'h3C);
    drain();
  endtask

  task automatic test_async_reset();
    if (o_free !== 1'b1) send(32'h7000, 8'h01);
    send(32'h7004, 8'h01);
    if (o_free !== 1'b1) send(32'h7008, 8'h01);
    checks++;
    if (o_free !== 1'b1 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_setup free %b valid %b want 1 1", o_free, o_valid);
    end
    #2;
    rst = 1'b0;
    i_drive = 1'b0;
    #1;
    checks++;
    if (o_free !== 1'b0 || o_valid !== 1'b0 || o_level !== 0) begin
      errors++;
      $display("FAIL arst free %b valid %b lvl %0d want 0 0 0",
               o_free, o_valid, o_level);
    end
    sb.delete();
    tick();
    rst = 1'b1;
    tick();
    send(32'h8000, 8'h55);
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pops = 0;
    max_lvl = 0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
